// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: core request/response channel and memory-bus signals of mem_bus_master.
interface mem_bus_master_if #(
    parameter int AWIDTH = 5
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [1:0]        i_req_size;
    logic              i_req_unsigned;
    logic [AWIDTH+1:0] i_req_addr;
    logic [31:0]       i_req_wdata;
    logic              o_rsp_valid;
    logic [31:0]       o_rsp_rdata;
    logic              o_rsp_err;
    logic              o_cyc;
    logic              o_stb;
    logic              o_we;
    logic [AWIDTH-1:0] o_addr;
    logic [31:0]       o_wdata;
    logic [31:0]       i_rdata;
    logic              i_ack;
    logic              i_stall;
    modport master (
        input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
        input  i_rdata, i_ack, i_stall,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_cyc, o_stb, o_we, o_addr, o_wdata
    );
    modport slave (
        output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
        output i_rdata, i_ack, i_stall,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_cyc, o_stb, o_we, o_addr, o_wdata
    );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master: load/store initiator on the cyc/stb/we/ack/stall bus, sub-word stores by read-modify-write.
// Define MEM_BUS_MASTER_TIMEOUT_EN to abort any bus phase that lasts TIMEOUT cycles.
module mem_bus_master #(
    parameter int AWIDTH  = 5,
    parameter int TIMEOUT = 16
) (
    input logic m_clk,
    input logic m_rst,
    mem_bus_master_if.master bus
);
    localparam logic [2:0] IDLE = 3'd0, RD_REQ = 3'd1, RD_WAIT = 3'd2, WR_REQ = 3'd3, WR_WAIT = 3'd4, RESP = 3'd5;
    logic [2:0]        state;
    logic              we, uns, err;
    logic [1:0]        size;
    logic [AWIDTH+1:0] addr;
    logic [15:0]       wdata;
    logic [31:0]       data;
    logic [31:0]       mask, sdat, ld;
    logic [15:0]       lane;
    logic              bad, busy, to;
    always_comb begin
        bad  = bus.i_req_size == 2'b11 || (bus.i_req_size == 2'b01 && bus.i_req_addr[0])
            || (bus.i_req_size == 2'b10 && bus.i_req_addr[1:0] != 2'b00);
        busy = state == RD_REQ || state == RD_WAIT || state == WR_REQ || state == WR_WAIT;
        mask = size == 2'b00 ? 32'hFF << {addr[1:0], 3'b000} : 32'hFFFF << {addr[1], 4'b0000};
        sdat = size == 2'b00 ? {4{wdata[7:0]}} : {2{wdata}};
        lane = 16'(data >> {addr[1:0], 3'b000});
        ld   = size == 2'b10 ? data
             : size == 2'b01 ? {{16{lane[15] & ~uns}}, lane}
             : {{24{lane[7] & ~uns}}, lane[7:0]};
    end
`ifdef MEM_BUS_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    assign to = cnt == CW'(TIMEOUT - 1);
    // restarts at every REQ entry: from IDLE, or when the read half of an RMW completes
    always_ff @(posedge m_clk or negedge m_rst)
        if (!m_rst) cnt <= '0;
        else cnt <= (!busy || (state == RD_WAIT && bus.i_ack)) ? '0 : cnt + 1'b1;
`else
    assign to = TIMEOUT < 0;
`endif
    always_ff @(posedge m_clk or negedge m_rst)
        if (!m_rst) begin
            state <= IDLE;
            we    <= 1'b0;
            uns   <= 1'b0;
            err   <= 1'b0;
            size  <= 2'b00;
            addr  <= '0;
            wdata <= '0;
            data  <= '0;
        end else if (busy && to) begin
            state <= RESP;
            err   <= 1'b1;
        end else case (state)
            IDLE: if (bus.i_req_valid) begin
                we    <= bus.i_req_we;
                uns   <= bus.i_req_unsigned;
                size  <= bus.i_req_size;
                addr  <= bus.i_req_addr;
                wdata <= bus.i_req_wdata[15:0];
                data  <= bus.i_req_wdata;
                err   <= bad;
                state <= bad ? RESP : (bus.i_req_we && bus.i_req_size == 2'b10) ? WR_REQ : RD_REQ;
            end
            RD_REQ:  if (!bus.i_stall) state <= RD_WAIT;
            WR_REQ:  if (!bus.i_stall) state <= WR_WAIT;
            RD_WAIT: if (bus.i_ack) begin
                data  <= we ? (bus.i_rdata & ~mask) | (sdat & mask) : bus.i_rdata;
                state <= we ? WR_REQ : RESP;
            end
            WR_WAIT: if (bus.i_ack) state <= RESP;
            default: state <= IDLE;
        endcase
    assign bus.o_req_ready = state == IDLE;
    assign bus.o_cyc       = busy;
    assign bus.o_stb       = state == RD_REQ || state == WR_REQ;
    assign bus.o_we        = state == WR_REQ;
    assign bus.o_rsp_valid = state == RESP;
    assign bus.o_rsp_err   = state == RESP && err;
    assign bus.o_rsp_rdata = (state == RESP && !err && !we) ? ld : '0;
    assign bus.o_addr      = addr[AWIDTH+1:2];
    assign bus.o_wdata     = data;
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed and randomized load/store traffic against a bus memory and a request-level reference.
module tb_mem_bus_master;
    localparam int AW = 5;
    logic m_clk = 1'b0;
    logic m_rst = 1'b0;
    always #5 m_clk = ~m_clk;
    mem_bus_master_if #(.AWIDTH(AW)) bus ();
    mem_bus_master #(.AWIDTH(AW), .TIMEOUT(4)) dut (.m_clk(m_clk), .m_rst(m_rst), .bus(bus));
    logic [31:0] mem     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    int n_chk = 0, n_fail = 0;
    bit rnd_en = 0, noack = 0, stray = 0, pend = 0;
    int fstall = 0, dly = 0, n_stall = 0, n_dly = 0, n_ph = 0;
    logic [31:0] rdat = 0, last_wdata = 0;
    int g_lat, g_stb, g_cyc;
    logic [31:0] g_rdata;
    logic g_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] sz, input bit u, input logic [1:0] lo);
        int unsigned v;
        if (sz == 2) return w;
        if (sz == 0) begin
            v = (w >> (8 * lo)) % 256;
            return (u || v < 128) ? v : v + 32'hFFFFFF00;
        end
        v = (w >> (16 * lo[1])) % 65536;
        return (u || v < 32768) ? v : v + 32'hFFFF0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz, input logic [1:0] lo, input logic [31:0] d);
        int unsigned sh, m;
        sh = sz == 0 ? 8 * lo : 16 * lo[1];
        m  = sz == 0 ? 256 : 65536;
        return w - (((w >> sh) % m) << sh) + ((d % m) << sh);
    endfunction

    // memory slave: random stalls, ack delays and stray acks outside a pending phase
    initial begin
        bus.i_ack = 0; bus.i_stall = 0; bus.i_rdata = 0;
        forever begin
            @(negedge m_clk);
            bus.i_ack = 0;
            bus.i_rdata = $urandom;
            if (!m_rst) pend = 0;
            else if (pend && !noack) begin
                if (dly == 0) begin bus.i_ack = 1; bus.i_rdata = rdat; pend = 0; end
                else begin dly--; n_dly++; end
            end else if (!pend) bus.i_ack = rnd_en && $urandom_range(7) == 0;
            bus.i_stall = rnd_en && $urandom_range(3) == 0;
            if (m_rst && bus.o_stb) begin
                if (fstall > 0) begin bus.i_stall = 1; fstall--; end
                if (bus.i_stall) n_stall++;
                else begin
                    n_ph++; pend = 1; dly = rnd_en ? int'($urandom_range(2)) : 0;
                    if (bus.o_we) begin mem[bus.o_addr] = bus.o_wdata; last_wdata = bus.o_wdata; end
                    else rdat = mem[bus.o_addr];
                end
            end
            if (stray) bus.i_ack = 1;
        end
    end

    task automatic start(input bit we, input logic [1:0] sz, input bit u, input logic [AW+1:0] a, input logic [31:0] d);
        int k = 0;
        @(negedge m_clk);
        while (!bus.o_req_ready && k < 50) begin @(negedge m_clk); k++; end
        check("req_ready", bus.o_req_ready, 1);
        bus.i_req_valid = 1; bus.i_req_we = we; bus.i_req_size = sz;
        bus.i_req_unsigned = u; bus.i_req_addr = a; bus.i_req_wdata = d;
        n_stall = 0; n_dly = 0; n_ph = 0;
    endtask

    task automatic wait_rsp();
        bit done = 0;
        g_lat = 0; g_stb = 0; g_cyc = 0; g_rdata = 0; g_err = 0;
        while (!done && g_lat < 300) begin
            @(negedge m_clk);
            g_lat++;
            if (g_lat == 1) begin
                bus.i_req_valid = 0; bus.i_req_we = 1'($urandom); bus.i_req_size = 2'($urandom);
                bus.i_req_unsigned = 1'($urandom); bus.i_req_addr = $urandom; bus.i_req_wdata = $urandom;
            end
            if (bus.o_stb) g_stb++;
            if (bus.o_cyc) g_cyc++;
            if (bus.o_rsp_valid) begin done = 1; g_rdata = bus.o_rsp_rdata; g_err = bus.o_rsp_err; end
        end
        if (!done) check("rsp_bound", 0, 1);
    endtask

    task automatic do_req(input bit we, input logic [1:0] sz, input bit u, input logic [AW+1:0] a, input logic [31:0] d);
        logic [AW-1:0] w = a[AW+1:2];
        bit bad = sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
        int ph = bad ? 0 : (we && sz != 2) ? 2 : 1;
        logic [31:0] exp_rd = (bad || we) ? 32'd0 : ext(ref_mem[w], sz, u, a[1:0]);
        start(we, sz, u, a, d);
        wait_rsp();
        if (!bad && we) ref_mem[w] = sz == 2 ? d : merge(ref_mem[w], sz, a[1:0], d);
        check("rsp_err", g_err, bad);
        check("rsp_rdata", g_rdata, exp_rd);
        check("bus_phases", n_ph, ph);
        check("latency", g_lat, bad ? 1 : 1 + 2 * ph + n_stall + n_dly);
        check("stb_cycles", g_stb, ph + n_stall);
        check("cyc_span", g_cyc, g_lat - 1);
        @(negedge m_clk);
        check("rsp_pulse", {bus.o_rsp_valid, bus.o_req_ready}, 2'b01);
    endtask

    initial begin
        int k;
        bus.i_req_valid = 0; bus.i_req_we = 0; bus.i_req_size = 0;
        bus.i_req_unsigned = 0; bus.i_req_addr = 0; bus.i_req_wdata = 0;
        for (int i = 0; i < (1 << AW); i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        #1;
        check("reset_ctl", {bus.o_req_ready, bus.o_cyc, bus.o_stb, bus.o_we, bus.o_rsp_valid, bus.o_rsp_err}, 6'b100000);
        check("reset_data", bus.o_rsp_rdata | bus.o_wdata | 32'(bus.o_addr), 0);
        @(negedge m_clk); m_rst = 1;

        mem[2] = 32'h8899AABB; ref_mem[2] = mem[2];
        do_req(0, 2, 0, 7'h08, 0);
        check("plan_word_load", g_rdata, 32'h8899AABB);
        check("plan_word_lat", g_lat, 3);
        mem[2] = 32'h80123456; ref_mem[2] = mem[2];
        do_req(0, 0, 0, 7'h0B, 0);
        check("plan_byte_signed", g_rdata, 32'hFFFFFF80);
        do_req(0, 0, 1, 7'h0B, 0);
        check("plan_byte_unsigned", g_rdata, 32'h00000080);
        mem[1] = 32'h11223344; ref_mem[1] = mem[1];
        do_req(1, 1, 0, 7'h06, 32'hBEEF);
        check("plan_half_merge", last_wdata, 32'hBEEF3344);
        check("plan_half_lat", g_lat, 5);
        do_req(0, 2, 0, 7'h04, 0);
        check("plan_half_readback", g_rdata, 32'hBEEF3344);
        fstall = 2;
        do_req(0, 2, 0, 7'h08, 0);
        check("plan_stall_stb", g_stb, 3);
        check("plan_stall_lat", g_lat, 5);
        do_req(1, 2, 0, 7'h02, 32'h12345678);
        check("plan_misaligned_err", g_err, 1);
        do_req(1, 0, 0, 7'h03, 32'hA5);
        check("plan_byte_rmw", n_ph, 2);

        noack = 1;
        start(0, 2, 0, 7'h08, 0);
        k = 0;
        do begin
            @(negedge m_clk); k++;
            if (k == 1) bus.i_req_valid = 0;
        end while (!(bus.o_cyc && !bus.o_stb) && k < 20);
        #2 m_rst = 0;
        #1;
        check("midrst_ctl", {bus.o_req_ready, bus.o_cyc, bus.o_stb, bus.o_we, bus.o_rsp_valid, bus.o_rsp_err}, 6'b100000);
        check("midrst_data", bus.o_rsp_rdata | bus.o_wdata | 32'(bus.o_addr), 0);
        noack = 0;
        @(negedge m_clk); @(negedge m_clk);
        m_rst = 1; stray = 1;
        k = 0;
        repeat (4) begin
            @(negedge m_clk);
            if (bus.o_rsp_valid || bus.o_cyc || !bus.o_req_ready) k++;
        end
        stray = 0;
        check("stray_ack_ignored", k, 0);

`ifdef MEM_BUS_MASTER_TIMEOUT_EN
        noack = 1;
        start(0, 2, 0, 7'h08, 0);
        wait_rsp();
        check("timeout_cyc", g_cyc, 4);
        check("timeout_err", g_err, 1);
        check("timeout_rdata", g_rdata, 0);
        #1 pend = 0; noack = 0;
`endif

        rnd_en = 1;
        repeat (250) begin
            logic [1:0] sz;
            logic [AW+1:0] a;
            sz = $urandom_range(11) == 0 ? 2'd3 : 2'($urandom_range(2));
            a = 7'($urandom);
            if ($urandom_range(3) != 0) a = sz == 2 ? {a[AW+1:2], 2'b00} : sz == 1 ? {a[AW+1:1], 1'b0} : a;
            do_req(1'($urandom_range(1)), sz, 1'($urandom_range(1)), a, $urandom);
        end
        k = 0;
        for (int i = 0; i < (1 << AW); i++) if (mem[i] !== ref_mem[i]) k++;
        check("mem_image", k, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d comparisons so far", n_chk);
        $fatal(1);
    end
endmodule
